// File: rtl/nn_pio_cmd_bridge_if.sv
// PIO command/response and shared memory-port bundle for nn_pio_cmd_bridge.
// The bridge uses the slave view; the NIOS PIO side and memories use the master view.
interface nn_pio_cmd_bridge_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13
);
  logic [15:0]            cmd_sync;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [DATA_W-1:0]      cmd_wdata;
  logic [DATA_W-1:0]      rsp_data;
  logic [3:0]             rsp_status;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [NUM_CH-1:0]      mem_we;
  logic [NUM_CH-1:0]      mem_re;
  logic [NUM_CH*DATA_W-1:0] mem_rdata;

  modport slave (
    input  cmd_sync, cmd_addr, cmd_wdata, mem_rdata,
    output rsp_data, rsp_status, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output cmd_sync, cmd_addr, cmd_wdata, mem_rdata,
    input  rsp_data, rsp_status, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/nn_pio_cmd_bridge.sv
// Toggle-handshake command engine: single/auto-increment write, fill and read
// from the NIOS PIOs to NUM_CH on-chip memories over one shared registered port.
module nn_pio_cmd_bridge #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned RD_LAT = 2
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  nn_pio_cmd_bridge_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_FILL, S_RD_WAIT, S_ERR, S_DONE} state_e;
  typedef enum logic [1:0] {OP_WRITE, OP_WRITE_INC, OP_READ, OP_FILL} op_e;

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [2:0]          ch_q, ch_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_CH-1:0]   we_q, we_d;
  logic [NUM_CH-1:0]   re_q, re_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  op_e                 cmd_op;
  logic [2:0]          cmd_ch;
  logic [NUM_CH-1:0]   cmd_oh;
  logic [DATA_W-1:0]   rd_sel;
  logic                unused_sync;

  assign cmd_op      = op_e'(bus.cmd_sync[2:1]);
  assign cmd_ch      = bus.cmd_sync[5:3];
  assign cmd_oh      = NUM_CH'(1) << cmd_ch;
  assign unused_sync = ^bus.cmd_sync[7:6];

  always_comb begin
    rd_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_q == 3'(c)) rd_sel = bus.mem_rdata[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = '0;
    re_d    = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (!armed_q) begin
          ack_d   = bus.cmd_sync[0];
          armed_d = 1'b1;
        end else if (bus.cmd_sync[0] != ack_q) begin
          ch_d  = cmd_ch;
          err_d = 1'b0;
          if (32'(cmd_ch) >= NUM_CH) begin
            // Invalid channel acks on the acceptance edge; ERR stands in for DONE.
            err_d   = 1'b1;
            ack_d   = ~ack_q;
            state_d = S_ERR;
          end else begin
            busy_d  = 1'b1;
            wdata_d = bus.cmd_wdata;
            unique case (cmd_op)
              OP_WRITE: begin
                we_d    = cmd_oh;
                addr_d  = bus.cmd_addr;
                ptr_d   = bus.cmd_addr + ADDR_W'(1);
                state_d = S_EXEC;
              end
              OP_WRITE_INC: begin
                we_d    = cmd_oh;
                addr_d  = ptr_q;
                ptr_d   = ptr_q + ADDR_W'(1);
                err_d   = (ptr_q == '1);
                state_d = S_EXEC;
              end
              OP_READ: begin
                re_d    = cmd_oh;
                addr_d  = bus.cmd_addr;
                cnt_d   = '0;
                state_d = S_RD_WAIT;
              end
              default: begin
                we_d    = cmd_oh;
                addr_d  = bus.cmd_addr;
                cnt_d   = bus.cmd_sync[15:8];
                state_d = S_FILL;
              end
            endcase
          end
        end
      end
      S_EXEC: begin
        busy_d  = 1'b0;
        ack_d   = ~ack_q;
        state_d = S_DONE;
      end
      S_FILL: begin
        // cnt_q holds writes still owed after the current one.
        if (cnt_q == '0 || addr_q == '1) begin
          err_d   = err_q | (cnt_q != '0);
          busy_d  = 1'b0;
          ack_d   = ~ack_q;
          state_d = S_DONE;
        end else begin
          we_d   = we_q;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - 8'd1;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 8'(RD_LAT)) begin
          rdata_d = rd_sel;
          busy_d  = 1'b0;
          ack_d   = ~ack_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ERR:   state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      re_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rsp_data   = rdata_q;
  assign bus.rsp_status = {1'b0, err_q, busy_q, ack_q};
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_re     = re_q;

endmodule

// File: tb/tb_nn_pio_cmd_bridge.sv
// Directed bench for nn_pio_cmd_bridge: PIO-side command driver, write logger
// and a two-stage read pipeline standing in for the channel-2 memory.
module tb_nn_pio_cmd_bridge;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned RD_LAT = 2;

  typedef struct {
    logic [NUM_CH-1:0] we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic tog;
  int   checks;
  int   failures;
  wr_t  wlog[$];
  logic [DATA_W-1:0] p1, p2;

  nn_pio_cmd_bridge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  nn_pio_cmd_bridge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .bus          (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] rd_lookup(input logic [ADDR_W-1:0] a);
    return (a == 13'h010) ? 32'h40490FDB : (32'h7000_0000 | 32'(a));
  endfunction

  // Channel 2 returns data RD_LAT cycles after the strobe cycle; other channels hold markers.
  always @(posedge clk) begin
    p1 <= bus.mem_re[2] ? rd_lookup(bus.mem_addr) : 32'h0BAD_0BAD;
    p2 <= p1;
    if (bus.mem_we != '0) wlog.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
  end

  assign bus.mem_rdata = {32'hBAD0_0003, p2, 32'hBAD0_0001, 32'hBAD0_0000};

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] ch, input logic [7:0] lenm1,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    tog           = ~tog;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_sync  = {lenm1, 2'b00, ch, op, tog};
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    tog = 1'b1;
    bus.cmd_sync = 16'h0001;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    cyc(2);
    checks++;
    if (bus.rsp_status !== 4'b0000 || bus.mem_we !== 4'b0 || bus.mem_re !== 4'b0 ||
        bus.rsp_data !== 32'h0 || bus.mem_addr !== 13'h0) begin
      failures++;
      $display("FAIL reset_state: status=%b we=%b re=%b rsp=%h addr=%h expected all zero",
               bus.rsp_status, bus.mem_we, bus.mem_re, bus.rsp_data, bus.mem_addr);
    end
    rst_n = 1'b1;
    cyc(1);
    checks++;
    if (bus.rsp_status !== 4'b0001) begin
      failures++;
      $display("FAIL arm_status: status=%b expected 0001", bus.rsp_status);
    end
    bad = 0;
    repeat (10) begin
      cyc(1);
      if (bus.mem_we !== 4'b0 || bus.mem_re !== 4'b0 || bus.rsp_status !== 4'b0001) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_after_arm: %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_write();
    wlog.delete();
    issue(2'b00, 3'd1, 8'd0, 13'h005, 32'h3F800000);
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0010 || bus.mem_addr !== 13'h005 || bus.mem_wdata !== 32'h3F800000 ||
        bus.rsp_status !== {3'b001, ~tog}) begin
      failures++;
      $display("FAIL write_strobe: we=%b addr=%h data=%h status=%b expected 0010 005 3f800000 %b",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rsp_status, {3'b001, ~tog});
    end
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0 || bus.rsp_status !== {3'b000, tog}) begin
      failures++;
      $display("FAIL write_ack: we=%b status=%b expected 0000 %b", bus.mem_we, bus.rsp_status, {3'b000, tog});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      issue(2'b01, 3'd1, 8'd0, 13'h1ABC, 32'h1000_0000 + 32'(i));
      cyc(1);
      checks++;
      if (bus.mem_we !== 4'b0010 || bus.mem_addr !== 13'(6 + i) || bus.mem_wdata !== 32'h1000_0000 + 32'(i)) begin
        failures++;
        $display("FAIL winc_strobe%0d: we=%b addr=%h data=%h expected 0010 %h %h", i,
                 bus.mem_we, bus.mem_addr, bus.mem_wdata, 13'(6 + i), 32'h1000_0000 + 32'(i));
      end
      cyc(1);
      checks++;
      if (bus.rsp_status !== {3'b000, tog}) begin
        failures++;
        $display("FAIL winc_ack%0d: status=%b expected %b", i, bus.rsp_status, {3'b000, tog});
      end
    end
    checks++;
    if (wlog.size() != 4 || wlog[0].addr !== 13'h005 || wlog[1].addr !== 13'h006 ||
        wlog[2].addr !== 13'h007 || wlog[3].addr !== 13'h008) begin
      failures++;
      $display("FAIL write_log: %0d writes expected 4 at 005..008", wlog.size());
    end
  endtask

  task automatic test_read();
    cyc(1);
    issue(2'b10, 3'd2, 8'd0, 13'h010, 32'hFFFF_FFFF);
    cyc(1);
    checks++;
    if (bus.mem_re !== 4'b0100 || bus.mem_we !== 4'b0 || bus.mem_addr !== 13'h010 ||
        bus.rsp_status !== {3'b001, ~tog}) begin
      failures++;
      $display("FAIL read_strobe: re=%b we=%b addr=%h status=%b expected 0100 0000 010 %b",
               bus.mem_re, bus.mem_we, bus.mem_addr, bus.rsp_status, {3'b001, ~tog});
    end
    cyc(2);
    checks++;
    if (bus.mem_re !== 4'b0 || bus.rsp_status !== {3'b001, ~tog}) begin
      failures++;
      $display("FAIL read_wait: re=%b status=%b expected 0000 %b", bus.mem_re, bus.rsp_status, {3'b001, ~tog});
    end
    cyc(1);
    checks++;
    if (bus.rsp_status !== {3'b000, tog} || bus.rsp_data !== 32'h40490FDB) begin
      failures++;
      $display("FAIL read_data: status=%b rsp=%h expected %b 40490fdb", bus.rsp_status, bus.rsp_data, {3'b000, tog});
    end
  endtask

  task automatic test_fill_boundary();
    cyc(1);
    wlog.delete();
    issue(2'b11, 3'd0, 8'd3, 13'h1FFE, 32'hC000_0000);
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0001 || bus.mem_addr !== 13'h1FFE || bus.mem_wdata !== 32'hC000_0000) begin
      failures++;
      $display("FAIL fill_first: we=%b addr=%h data=%h expected 0001 1ffe c0000000", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0001 || bus.mem_addr !== 13'h1FFF) begin
      failures++;
      $display("FAIL fill_max: we=%b addr=%h expected 0001 1fff", bus.mem_we, bus.mem_addr);
    end
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0 || bus.rsp_status !== {3'b010, tog} || wlog.size() != 2) begin
      failures++;
      $display("FAIL fill_stop: we=%b status=%b writes=%0d expected 0000 %b 2",
               bus.mem_we, bus.rsp_status, wlog.size(), {3'b010, tog});
    end
  endtask

  task automatic test_wrap_inc();
    cyc(1);
    issue(2'b00, 3'd3, 8'd0, 13'h1FFE, 32'hAAAA_0001);
    cyc(3);
    issue(2'b01, 3'd3, 8'd0, 13'h0, 32'hAAAA_0002);
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b1000 || bus.mem_addr !== 13'h1FFF || bus.rsp_status !== {3'b011, ~tog}) begin
      failures++;
      $display("FAIL winc_wrap: we=%b addr=%h status=%b expected 1000 1fff %b",
               bus.mem_we, bus.mem_addr, bus.rsp_status, {3'b011, ~tog});
    end
    cyc(2);
    issue(2'b01, 3'd3, 8'd0, 13'h0, 32'hAAAA_0003);
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b1000 || bus.mem_addr !== 13'h0000 || bus.rsp_status !== {3'b001, ~tog}) begin
      failures++;
      $display("FAIL winc_zero: we=%b addr=%h status=%b expected 1000 0000 %b",
               bus.mem_we, bus.mem_addr, bus.rsp_status, {3'b001, ~tog});
    end
    cyc(1);
  endtask

  task automatic test_bad_channel();
    cyc(1);
    issue(2'b00, 3'd5, 8'd0, 13'h040, 32'h1234_5678);
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0 || bus.mem_re !== 4'b0 || bus.rsp_status !== {3'b010, tog}) begin
      failures++;
      $display("FAIL bad_channel: we=%b re=%b status=%b expected 0000 0000 %b",
               bus.mem_we, bus.mem_re, bus.rsp_status, {3'b010, tog});
    end
    cyc(1);
    issue(2'b00, 3'd3, 8'd0, 13'h020, 32'h5555_AAAA);
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b1000 || bus.mem_addr !== 13'h020 || bus.rsp_status !== {3'b001, ~tog}) begin
      failures++;
      $display("FAIL err_clear: we=%b addr=%h status=%b expected 1000 020 %b",
               bus.mem_we, bus.mem_addr, bus.rsp_status, {3'b001, ~tog});
    end
    cyc(1);
    checks++;
    if (bus.rsp_status !== {3'b000, tog} || bus.rsp_data !== 32'h40490FDB) begin
      failures++;
      $display("FAIL rsp_hold: status=%b rsp=%h expected %b 40490fdb", bus.rsp_status, bus.rsp_data, {3'b000, tog});
    end
  endtask

  task automatic test_back_to_back();
    logic first_tog;
    int   bad;
    cyc(1);
    wlog.delete();
    issue(2'b11, 3'd1, 8'd15, 13'h100, 32'h3F00_0000);
    first_tog = tog;
    cyc(3);
    issue(2'b00, 3'd2, 8'd0, 13'h200, 32'h4000_0000);
    cyc(13);
    checks++;
    if (bus.mem_we !== 4'b0010 || bus.mem_addr !== 13'h10F || bus.mem_wdata !== 32'h3F00_0000) begin
      failures++;
      $display("FAIL b2b_last_fill: we=%b addr=%h data=%h expected 0010 10f 3f000000", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0 || bus.rsp_status !== {3'b000, first_tog}) begin
      failures++;
      $display("FAIL b2b_first_ack: we=%b status=%b expected 0000 %b", bus.mem_we, bus.rsp_status, {3'b000, first_tog});
    end
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0 || bus.rsp_status !== {3'b000, first_tog}) begin
      failures++;
      $display("FAIL b2b_gap: we=%b status=%b expected 0000 %b", bus.mem_we, bus.rsp_status, {3'b000, first_tog});
    end
    cyc(1);
    checks++;
    if (bus.mem_we !== 4'b0100 || bus.mem_addr !== 13'h200 || bus.mem_wdata !== 32'h4000_0000 ||
        bus.rsp_status !== {3'b001, first_tog}) begin
      failures++;
      $display("FAIL b2b_second: we=%b addr=%h data=%h status=%b expected 0100 200 40000000 %b",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rsp_status, {3'b001, first_tog});
    end
    cyc(1);
    checks++;
    if (bus.rsp_status !== {3'b000, tog}) begin
      failures++;
      $display("FAIL b2b_second_ack: status=%b expected %b", bus.rsp_status, {3'b000, tog});
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i >= wlog.size()) bad++;
      else if (wlog[i].we !== 4'b0010 || wlog[i].addr !== 13'(13'h100 + i) || wlog[i].data !== 32'h3F00_0000) bad++;
    end
    checks++;
    if (bad != 0 || wlog.size() != 17) begin
      failures++;
      $display("FAIL b2b_log: %0d writes with %0d bad fill entries expected 17 and 0", wlog.size(), bad);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    int bad;
    cyc(1);
    issue(2'b11, 3'd0, 8'd31, 13'h300, 32'h1111_1111);
    cyc(4);
    checks++;
    if (bus.mem_we !== 4'b0001 || bus.mem_addr !== 13'h303) begin
      failures++;
      $display("FAIL mid_fill: we=%b addr=%h expected 0001 303", bus.mem_we, bus.mem_addr);
    end
    #2;
    rst_n = 1'b0;
    n0 = wlog.size();
    #1;
    checks++;
    if (bus.mem_we !== 4'b0 || bus.rsp_status !== 4'b0000) begin
      failures++;
      $display("FAIL async_drop: we=%b status=%b expected 0000 0000", bus.mem_we, bus.rsp_status);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    checks++;
    if (bus.rsp_status !== {3'b000, tog}) begin
      failures++;
      $display("FAIL rearm: status=%b expected %b", bus.rsp_status, {3'b000, tog});
    end
    bad = 0;
    repeat (6) begin
      cyc(1);
      if (bus.mem_we !== 4'b0 || bus.rsp_status !== {3'b000, tog}) bad++;
    end
    checks++;
    if (bad != 0 || wlog.size() != n0) begin
      failures++;
      $display("FAIL no_resume: %0d bad cycles, %0d new writes expected 0 and 0", bad, wlog.size() - n0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write();
    test_read();
    test_fill_boundary();
    test_wrap_inc();
    test_bad_channel();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
